// File: rtl/pipe_elastic_chain.sv
// Elastic chain of DEPTH valid/data register stages with global stall and per-stage flush kill.
// Latency: DEPTH cycles input-to-output on an empty chain; 1 item/cycle sustained throughput.
// Backpressure: combinational ready chain from out_ready; stall freezes both ends; optional perf counters under PIPE_PERF_CNT_EN.
module pipe_elastic_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         stall,
  input  logic [DEPTH-1:0]             flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  bubble_cycles
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  // A slot is free when empty or being flushed this cycle.
  assign free = ~valid_q | flush;

  // Stage i can load when it, or any stage downstream of it, frees up, or the consumer takes the head.
  // Written as a flattened OR over the downstream slots rather than a ripple to keep the logic loop-free.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | (|(free >> g));
  end

  assign in_ready  = rdy[0] & ~stall & rst;
  assign out_valid = valid_q[DEPTH-1] & ~flush[DEPTH-1] & ~stall;
  assign out_data  = data_q[DEPTH-1];

  // Source of each stage's load: the producer for stage 0, otherwise the upstream stage minus any kill.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1] & ~flush[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  // Stage registers: shift when ready, clear on flush during stall, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (stall) begin
          if (flush[i]) valid_q[i] <= 1'b0;
        end else if (rdy[i]) begin
          valid_q[i] <= src_valid[i];
          data_q[i]  <= src_data[i];
        end
      end
    end
  end

  // Live-item count taken from the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counters for stalled cycles and output bubbles outside stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (!stall && !out_valid && bubble_cycles != 32'hFFFF_FFFF)
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule
